seg7_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It holds one BCD digit per position and sequences a single shared BCD-to-7-segment decoder across the digits. It drives active-low anode enables with a ghosting guard band, and applies new display values only at frame boundaries so the display never shows a partial update. It sits between the counter/datapath logic that produces BCD values and the board's segment and anode pins.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/bcd_seg_dec.sv | 29 ++
 rtl/seg7_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller.
// Holds the active-low segment patterns (a..g at bits 6..0), the scan FSM state
// type and the slot-counter width helper.
package seg7_pkg;

  // Active-low segment patterns, a..g = bits 6..0
  localparam logic [6:0] SEG_BLANK = 7'b111_1111;
  localparam logic [6:0] SEG_0     = 7'b000_0001;
  localparam logic [6:0] SEG_1     = 7'b100_1111;
  localparam logic [6:0] SEG_2     = 7'b001_0010;
  localparam logic [6:0] SEG_3     = 7'b000_0110;
  localparam logic [6:0] SEG_4     = 7'b100_1100;
  localparam logic [6:0] SEG_5     = 7'b010_0100;
  localparam logic [6:0] SEG_6     = 7'b010_0000;
  localparam logic [6:0] SEG_7     = 7'b000_1111;
  localparam logic [6:0] SEG_8     = 7'b000_0000;
  localparam logic [6:0] SEG_9     = 7'b000_0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } scan_state_t;

  // Width of a counter that spans 0..refresh_div-1 (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned refresh_div);
    return (refresh_div > 1) ? int'($clog2(refresh_div)) : 1;
  endfunction

endpackage

// File: rtl/bcd_seg_dec.sv
// Combinational BCD to 7-segment decoder, active-low outputs.
// Ports:
//   bcd   in  4 : BCD digit; values 10..15 decode to blank
//   seg_c out 7 : segments a..g at bits 6..0, active-low
module bcd_seg_dec
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit 7-segment
// display. One shared decoder is sequenced across the digits; each digit slot
// starts with a guard band of all anodes off, and newly loaded values are only
// applied at frame boundaries (digit index wrap, or leaving IDLE).
// Optional feature: define SEG7_LZB_EN for leading-zero blanking.
// Ports:
//   clk         in  1             : clock, rising edge
//   rst         in  1             : asynchronous active-high reset
//   enable      in  1             : scan enable
//   load        in  1             : strobe capturing bcd_in/dp_in
//   bcd_in      in  4*NUM_DIGITS  : digit k at [4k+3:4k], digit 0 rightmost
//   dp_in       in  NUM_DIGITS    : decimal points, 1 = lit
//   seg         out 7             : segments a..g, active-low
//   dp          out 1             : decimal point, active-low
//   an          out NUM_DIGITS    : anode enables, active-low, one-hot-low
//   pending     out 1             : loaded value waiting for a frame boundary
//   frame_start out 1             : pulse on the first cycle of digit 0's slot
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_start
);

  localparam int unsigned CNT_W = cnt_width(REFRESH_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam int BLANK_I = int'(BLANK_CYC);
  // With no guard band a slot opens directly in DRIVE
  localparam scan_state_t SLOT_START = (BLANK_CYC == 0) ? ST_DRIVE : ST_GUARD;

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  scan_state_t             state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    bnd;
  digits_t                 act_bcd, act_bcd_nxt, shd_bcd;
  logic [NUM_DIGITS-1:0]   act_dp, act_dp_nxt, shd_dp;
  logic [NUM_DIGITS-1:0]   lzb;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic                    dp_nxt;
  logic [3:0]              dec_in;
  logic [6:0]              dec_seg_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state, slot counter, digit index, frame boundary and active value
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    bnd         = 1'b0;
    act_bcd_nxt = act_bcd;
    act_dp_nxt  = act_dp;
    if (!enable) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      idx_nxt   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          bnd       = 1'b1;
          cnt_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = SLOT_START;
        end
        default: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = SLOT_START;
            if (idx == IDX_LAST) begin
              idx_nxt = '0;
              bnd     = 1'b1;
            end else begin
              idx_nxt = idx + IDX_W'(1);
            end
          end else begin
            cnt_nxt   = cnt + CNT_W'(1);
            state_nxt = (int'(cnt_nxt) < BLANK_I) ? ST_GUARD : ST_DRIVE;
          end
        end
      endcase
    end
    // A load on the boundary edge bypasses the shadow register
    if (bnd) begin
      if (load) begin
        act_bcd_nxt = bcd_in;
        act_dp_nxt  = dp_in;
      end else if (pending) begin
        act_bcd_nxt = shd_bcd;
        act_dp_nxt  = shd_dp;
      end
    end
  end

`ifdef SEG7_LZB_EN
  // Digit k is blanked when it and every digit above it are zero with no dp
  assign lzb[0] = 1'b0;
  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_lzb
    assign lzb[k] = (act_bcd_nxt[NUM_DIGITS-1:k] == '0) &&
                    (act_dp_nxt[NUM_DIGITS-1:k] == '0);
  end
`else
  assign lzb = '0;
`endif

  // Pin values for the upcoming cycle, computed from the next state/index
  always_comb begin
    an_nxt = '1;
    dp_nxt = 1'b1;
    dec_in = 4'hF;
    if (state_nxt == ST_DRIVE) begin
      an_nxt[idx_nxt] = 1'b0;
      dp_nxt          = ~act_dp_nxt[idx_nxt];
      if (!lzb[idx_nxt]) dec_in = act_bcd_nxt[idx_nxt];
    end
  end

  bcd_seg_dec u_dec (
    .bcd   (dec_in),
    .seg_c (dec_seg_c)
  );

  // Counters, value registers and registered pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      act_bcd     <= '0;
      act_dp      <= '0;
      shd_bcd     <= '0;
      shd_dp      <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      an          <= '1;
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      act_bcd     <= act_bcd_nxt;
      act_dp      <= act_dp_nxt;
      pending     <= bnd ? 1'b0 : (pending | load);
      frame_start <= bnd;
      seg         <= dec_seg_c;
      dp          <= dp_nxt;
      an          <= an_nxt;
      if (load && !bnd) begin
        shd_bcd <= bcd_in;
        shd_dp  <= dp_in;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, REFRESH_DIV=8,
// BLANK_CYC=2). A frame-position model predicts every pin each cycle.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = ND * RD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;
  logic        frame_start;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          m_run = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_disp = '0;
  logic [3:0]  m_ddp = '0;
  logic [15:0] m_sh = '0;
  logic [3:0]  m_shdp = '0;
  bit          m_pend = 1'b0;

  seg7_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .BLANK_CYC  (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load       (load),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .pending    (pending),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'd0: return 7'b000_0001;
      4'd1: return 7'b100_1111;
      4'd2: return 7'b001_0010;
      4'd3: return 7'b000_0110;
      4'd4: return 7'b100_1100;
      4'd5: return 7'b010_0100;
      4'd6: return 7'b010_0000;
      4'd7: return 7'b000_1111;
      4'd8: return 7'b000_0000;
      4'd9: return 7'b000_0100;
      default: return 7'b111_1111;
    endcase
  endfunction

  function automatic bit lz_blank(input int d);
    bit b;
    b = (d != 0);
`ifdef SEG7_LZB_EN
    for (int j = d; j < ND; j++)
      if (m_disp[4*j +: 4] != 4'd0 || m_ddp[j]) b = 1'b0;
`else
    b = 1'b0;
`endif
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic cmp_all();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int d, off;
    e_an = 4'hF;
    e_seg = 7'h7F;
    e_dp = 1'b1;
    if (m_run) begin
      d = m_pos / RD;
      off = m_pos % RD;
      if (off >= BL) begin
        e_an[d] = 1'b0;
        e_seg = lz_blank(d) ? 7'h7F : pat(m_disp[4*d +: 4]);
        e_dp = ~m_ddp[d];
      end
    end
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("dp", 32'(dp), 32'(e_dp));
    chk("frame_start", 32'(frame_start), 32'(m_run && m_pos == 0));
    chk("pending", 32'(pending), 32'(m_pend));
  endtask

  task automatic model_edge(input bit en, input bit ld, input logic [15:0] b, input logic [3:0] d);
    bit bnd;
    bnd = 1'b0;
    if (!en) m_run = 1'b0;
    else if (!m_run) begin
      m_run = 1'b1;
      m_pos = 0;
      bnd = 1'b1;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
      bnd = (m_pos == 0);
    end
    if (bnd) begin
      if (ld) begin
        m_disp = b;
        m_ddp = d;
      end else if (m_pend) begin
        m_disp = m_sh;
        m_ddp = m_shdp;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_sh = b;
      m_shdp = d;
      m_pend = 1'b1;
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0;
    m_pos = 0;
    m_disp = '0;
    m_ddp = '0;
    m_sh = '0;
    m_shdp = '0;
    m_pend = 1'b0;
  endtask

  // One clock: drive at negedge, model the edge, check just after it
  task automatic step(input bit en, input bit ld, input logic [15:0] b, input logic [3:0] d);
    enable = en;
    load = ld;
    bcd_in = b;
    dp_in = d;
    @(posedge clk);
    model_edge(en, ld, b, d);
    #1;
    cmp_all();
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
  endtask

  task automatic run_until(input int pos);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_run && m_pos == pos) break;
      step(1'b1, 1'b0, 16'($urandom), 4'($urandom));
    end
  endtask

  initial begin
    bit          r_en, r_ld;
    logic [15:0] r_b;
    logic [3:0]  r_d;

    // Reset state
    repeat (3) @(negedge clk);
    model_reset();
    cmp_all();
    rst = 1'b0;

    // Free run with no load: all digits show 0
    idle_steps(70);

    // Mid-frame load becomes pending, applied at the next boundary
    run_until(9);
    step(1'b1, 1'b1, 16'h1234, 4'h0);
    idle_steps(40);

    // Two loads then a load on the boundary edge itself
    run_until(5);
    step(1'b1, 1'b1, 16'h1111, 4'h0);
    idle_steps(3);
    step(1'b1, 1'b1, 16'h2222, 4'h0);
    run_until(31);
    step(1'b1, 1'b1, 16'h9999, 4'h0);
    idle_steps(32);

    // Non-BCD codes decode blank
    run_until(20);
    step(1'b1, 1'b1, 16'hF0A5, 4'h0);
    idle_steps(40);

    // Leading-zero patterns and a decimal point
    step(1'b1, 1'b1, 16'h0042, 4'h0);
    idle_steps(40);
    step(1'b1, 1'b1, 16'h0000, 4'h0);
    idle_steps(40);
    step(1'b1, 1'b1, 16'h0005, 4'b0100);
    idle_steps(40);

    // Enable dropped mid-DRIVE of digit 2, load while idle, re-enable
    run_until(20);
    step(1'b0, 1'b0, 16'h0, 4'h0);
    step(1'b0, 1'b1, 16'h5678, 4'b0001);
    repeat (3) step(1'b0, 1'b0, 16'($urandom), 4'($urandom));
    idle_steps(40);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r_en = ($urandom_range(0, 63) != 0);
      r_ld = ($urandom_range(0, 7) == 0);
      r_b = 16'($urandom);
      if ($urandom_range(0, 1) == 1) r_b = r_b & 16'h00FF;
      r_d = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      step(r_en, r_ld, r_b, r_d);
    end

    // Asynchronous reset mid-DRIVE discards a pending load
    run_until(11);
    step(1'b1, 1'b1, 16'h8765, 4'hF);
    step(1'b1, 1'b0, 16'h0, 4'h0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    cmp_all();
    @(negedge clk);
    rst = 1'b0;
    idle_steps(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
